// File: rtl/uart_piso_cfg.sv
// rtl/uart_piso_cfg.sv - UART TX serialiser with runtime length, parity and stop-bit config
// Frames a latched word as start/data(LSB first)/optional parity/stop bits, one bit per baud_clk.
module uart_piso_cfg #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5
) (
  input  logic              baud_clk,
  input  logic              reset_n,
  input  logic              send,
  input  logic [DATA_W-1:0] reg_data,
  input  logic [LEN_W-1:0]  data_len,
  input  logic [1:0]        parity_type,
  input  logic              stop_bits,
  output logic              data_tx,
  output logic              active_flag,
  output logic              done_flag
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(5);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              tx_q, tx_d;
  logic              active_q, active_d;
  logic              done_q, done_d;

  logic [LEN_W-1:0]  len_clamped;
  logic [DATA_W-1:0] len_mask;
  logic              par_calc;

  // Parity is computed at latch time over only the bits that will be sent.
  always_comb begin
    len_clamped = data_len;
    if (data_len < LEN_MIN) begin
      len_clamped = LEN_MIN;
    end else if (data_len > LEN_MAX) begin
      len_clamped = LEN_MAX;
    end
    for (int i = 0; i < DATA_W; i++) begin
      len_mask[i] = (LEN_W'(i) < len_clamped);
    end
    par_calc = (^(reg_data & len_mask)) ^ (parity_type == 2'b01);
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (send) begin
          state_d   = S_START;
          shift_d   = reg_data;
          len_d     = len_clamped;
          par_en_d  = ^parity_type;
          par_bit_d = par_calc;
          stop2_d   = stop_bits;
          tx_d      = 1'b0;
        end
      end
      S_START: begin
        state_d = S_DATA;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
        cnt_d   = LEN_W'(1);
      end
      S_DATA: begin
        // cnt_q counts bits already placed on the line.
        if (cnt_q >= len_q) begin
          if (par_en_q) begin
            state_d = S_PARITY;
            tx_d    = par_bit_q;
          end else begin
            state_d    = S_STOP;
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
          end
        end else begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + LEN_W'(1);
        end
      end
      S_PARITY: begin
        state_d    = S_STOP;
        tx_d       = 1'b1;
        stop_cnt_d = 1'b0;
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (stop_cnt_q == stop2_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          stop_cnt_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge baud_clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

  assign data_tx     = tx_q;
  assign active_flag = active_q;
  assign done_flag   = done_q;

endmodule

// File: tb/tb_uart_piso_cfg.sv
// tb/tb_uart_piso_cfg.sv - directed self-checking bench for uart_piso_cfg
// Samples are shifted in so expected literals read left-to-right in time order.
module tb_uart_piso_cfg;

  logic        baud_clk;
  logic        reset_n;
  logic        send;
  logic [7:0]  reg_data;
  logic [4:0]  data_len;
  logic [1:0]  parity_type;
  logic        stop_bits;
  logic        data_tx;
  logic        active_flag;
  logic        done_flag;

  logic        send16;
  logic [15:0] reg_data16;
  logic [4:0]  data_len16;
  logic [1:0]  parity_type16;
  logic        stop_bits16;
  logic        data_tx16;
  logic        active_flag16;
  logic        done_flag16;

  int pass_cnt;
  int total_cnt;

  uart_piso_cfg #(.DATA_W(8), .LEN_W(5)) dut (
    .baud_clk   (baud_clk),
    .reset_n    (reset_n),
    .send       (send),
    .reg_data   (reg_data),
    .data_len   (data_len),
    .parity_type(parity_type),
    .stop_bits  (stop_bits),
    .data_tx    (data_tx),
    .active_flag(active_flag),
    .done_flag  (done_flag)
  );

  uart_piso_cfg #(.DATA_W(16), .LEN_W(5)) dut16 (
    .baud_clk   (baud_clk),
    .reset_n    (reset_n),
    .send       (send16),
    .reg_data   (reg_data16),
    .data_len   (data_len16),
    .parity_type(parity_type16),
    .stop_bits  (stop_bits16),
    .data_tx    (data_tx16),
    .active_flag(active_flag16),
    .done_flag  (done_flag16)
  );

  initial baud_clk = 1'b0;
  always #5 baud_clk = ~baud_clk;

  task automatic set_cfg(input logic [7:0] d, input logic [4:0] len,
                         input logic [1:0] par, input logic stop);
    reg_data    = d;
    data_len    = len;
    parity_type = par;
    stop_bits   = stop;
  endtask

  // Called at a negedge; raises send, samples n negedges, drops send after sample drop_at.
  task automatic run_frame(input int n, input int drop_at,
                           output logic [31:0] tx_v, output logic [31:0] act_v,
                           output logic [31:0] done_v);
    tx_v = '0;
    act_v = '0;
    done_v = '0;
    send = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge baud_clk);
      tx_v   = {tx_v[30:0], data_tx};
      act_v  = {act_v[30:0], active_flag};
      done_v = {done_v[30:0], done_flag};
      if (k == drop_at) send = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    send = 1'b1;
    set_cfg(8'h4A, 5'd8, 2'b00, 1'b0);
    repeat (3) @(negedge baud_clk);
    total_cnt += 3;
    if (data_tx !== 1'b1) $display("FAIL rst_tx got %b exp 1", data_tx); else pass_cnt++;
    if (active_flag !== 1'b0) $display("FAIL rst_active got %b exp 0", active_flag); else pass_cnt++;
    if (done_flag !== 1'b0) $display("FAIL rst_done got %b exp 0", done_flag); else pass_cnt++;
    send = 1'b0;
    reset_n = 1'b1;
    @(negedge baud_clk);
    total_cnt++;
    if ({data_tx, active_flag, done_flag} !== 3'b100)
      $display("FAIL idle_after_rst got %b exp 100", {data_tx, active_flag, done_flag});
    else pass_cnt++;
  endtask

  task automatic test_8n1;
    logic [31:0] tx_v, act_v, done_v;
    set_cfg(8'h4A, 5'd8, 2'b00, 1'b0);
    run_frame(12, 0, tx_v, act_v, done_v);
    total_cnt += 3;
    if (tx_v !== 32'(12'b001010010111)) $display("FAIL 8n1_tx got %b exp %b", tx_v, 32'(12'b001010010111)); else pass_cnt++;
    if (act_v !== 32'(12'b111111111100)) $display("FAIL 8n1_active got %b exp %b", act_v, 32'(12'b111111111100)); else pass_cnt++;
    if (done_v !== 32'(12'b000000000010)) $display("FAIL 8n1_done got %b exp %b", done_v, 32'(12'b000000000010)); else pass_cnt++;
    set_cfg(8'h4A, 5'd31, 2'b00, 1'b0);
    run_frame(12, 0, tx_v, act_v, done_v);
    total_cnt++;
    if (tx_v !== 32'(12'b001010010111)) $display("FAIL len_clamp_hi_tx got %b exp %b", tx_v, 32'(12'b001010010111)); else pass_cnt++;
  endtask

  task automatic test_parity;
    logic [31:0] tx_v, act_v, done_v;
    set_cfg(8'h4A, 5'd8, 2'b01, 1'b0);
    run_frame(13, 0, tx_v, act_v, done_v);
    total_cnt += 3;
    if (tx_v !== 32'(13'b0010100100111)) $display("FAIL odd_tx got %b exp %b", tx_v, 32'(13'b0010100100111)); else pass_cnt++;
    if (act_v !== 32'(13'b1111111111100)) $display("FAIL odd_active got %b exp %b", act_v, 32'(13'b1111111111100)); else pass_cnt++;
    if (done_v !== 32'(13'b0000000000010)) $display("FAIL odd_done got %b exp %b", done_v, 32'(13'b0000000000010)); else pass_cnt++;
    set_cfg(8'h4A, 5'd8, 2'b10, 1'b0);
    run_frame(13, 0, tx_v, act_v, done_v);
    total_cnt++;
    if (tx_v !== 32'(13'b0010100101111)) $display("FAIL even_tx got %b exp %b", tx_v, 32'(13'b0010100101111)); else pass_cnt++;
    set_cfg(8'h4A, 5'd8, 2'b11, 1'b0);
    run_frame(12, 0, tx_v, act_v, done_v);
    total_cnt += 2;
    if (tx_v !== 32'(12'b001010010111)) $display("FAIL par11_tx got %b exp %b", tx_v, 32'(12'b001010010111)); else pass_cnt++;
    if (done_v !== 32'(12'b000000000010)) $display("FAIL par11_done got %b exp %b", done_v, 32'(12'b000000000010)); else pass_cnt++;
  endtask

  task automatic test_len_stop;
    logic [31:0] tx_v, act_v, done_v;
    set_cfg(8'h5A, 5'd7, 2'b10, 1'b1);
    run_frame(13, 0, tx_v, act_v, done_v);
    total_cnt += 3;
    if (tx_v !== 32'(13'b0010110101111)) $display("FAIL 7e2_tx got %b exp %b", tx_v, 32'(13'b0010110101111)); else pass_cnt++;
    if (act_v !== 32'(13'b1111111111100)) $display("FAIL 7e2_active got %b exp %b", act_v, 32'(13'b1111111111100)); else pass_cnt++;
    if (done_v !== 32'(13'b0000000000010)) $display("FAIL 7e2_done got %b exp %b", done_v, 32'(13'b0000000000010)); else pass_cnt++;
    set_cfg(8'h1F, 5'd3, 2'b00, 1'b0);
    run_frame(9, 0, tx_v, act_v, done_v);
    total_cnt += 3;
    if (tx_v !== 32'(9'b011111111)) $display("FAIL len_clamp_lo_tx got %b exp %b", tx_v, 32'(9'b011111111)); else pass_cnt++;
    if (act_v !== 32'(9'b111111100)) $display("FAIL len_clamp_lo_active got %b exp %b", act_v, 32'(9'b111111100)); else pass_cnt++;
    if (done_v !== 32'(9'b000000010)) $display("FAIL len_clamp_lo_done got %b exp %b", done_v, 32'(9'b000000010)); else pass_cnt++;
  endtask

  task automatic test_midframe_reset;
    logic [31:0] tx_v, act_v, done_v;
    set_cfg(8'h4A, 5'd8, 2'b00, 1'b0);
    run_frame(5, 0, tx_v, act_v, done_v);
    total_cnt++;
    if (tx_v !== 32'(5'b00101)) $display("FAIL prereset_tx got %b exp %b", tx_v, 32'(5'b00101)); else pass_cnt++;
    reset_n = 1'b0;
    @(negedge baud_clk);
    total_cnt += 3;
    if (data_tx !== 1'b1) $display("FAIL abort_tx got %b exp 1", data_tx); else pass_cnt++;
    if (active_flag !== 1'b0) $display("FAIL abort_active got %b exp 0", active_flag); else pass_cnt++;
    if (done_flag !== 1'b0) $display("FAIL abort_done got %b exp 0", done_flag); else pass_cnt++;
    reset_n = 1'b1;
    @(negedge baud_clk);
    total_cnt++;
    if ({data_tx, active_flag, done_flag} !== 3'b100)
      $display("FAIL abort_idle got %b exp 100", {data_tx, active_flag, done_flag});
    else pass_cnt++;
    run_frame(12, 0, tx_v, act_v, done_v);
    total_cnt += 2;
    if (tx_v !== 32'(12'b001010010111)) $display("FAIL post_reset_tx got %b exp %b", tx_v, 32'(12'b001010010111)); else pass_cnt++;
    if (done_v !== 32'(12'b000000000010)) $display("FAIL post_reset_done got %b exp %b", done_v, 32'(12'b000000000010)); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] tx_v, act_v, done_v;
    set_cfg(8'h4A, 5'd8, 2'b00, 1'b0);
    tx_v = '0;
    act_v = '0;
    done_v = '0;
    send = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge baud_clk);
      tx_v   = {tx_v[30:0], data_tx};
      act_v  = {act_v[30:0], active_flag};
      done_v = {done_v[30:0], done_flag};
      if (k == 0) set_cfg(8'h5A, 5'd7, 2'b10, 1'b1);
      if (k == 11) send = 1'b0;
    end
    total_cnt += 3;
    if (tx_v !== 32'(24'b001010010110010110101111))
      $display("FAIL b2b_tx got %b exp %b", tx_v, 32'(24'b001010010110010110101111));
    else pass_cnt++;
    if (act_v !== 32'(24'b111111111101111111111100))
      $display("FAIL b2b_active got %b exp %b", act_v, 32'(24'b111111111101111111111100));
    else pass_cnt++;
    if (done_v !== 32'(24'b000000000010000000000010))
      $display("FAIL b2b_done got %b exp %b", done_v, 32'(24'b000000000010000000000010));
    else pass_cnt++;
  endtask

  task automatic test_wide;
    logic [31:0] tx_v, act_v, done_v;
    reg_data16    = 16'hFFFF;
    data_len16    = 5'd16;
    parity_type16 = 2'b10;
    stop_bits16   = 1'b0;
    tx_v = '0;
    act_v = '0;
    done_v = '0;
    send16 = 1'b1;
    for (int k = 0; k < 21; k++) begin
      @(negedge baud_clk);
      tx_v   = {tx_v[30:0], data_tx16};
      act_v  = {act_v[30:0], active_flag16};
      done_v = {done_v[30:0], done_flag16};
      if (k == 0) send16 = 1'b0;
    end
    total_cnt += 3;
    if (tx_v !== 32'(21'b011111111111111110111))
      $display("FAIL wide_tx got %b exp %b", tx_v, 32'(21'b011111111111111110111));
    else pass_cnt++;
    if (act_v !== 32'(21'b111111111111111111100))
      $display("FAIL wide_active got %b exp %b", act_v, 32'(21'b111111111111111111100));
    else pass_cnt++;
    if (done_v !== 32'(21'b000000000000000000010))
      $display("FAIL wide_done got %b exp %b", done_v, 32'(21'b000000000000000000010));
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    send = 1'b0;
    send16 = 1'b0;
    reg_data16 = '0;
    data_len16 = 5'd8;
    parity_type16 = 2'b00;
    stop_bits16 = 1'b0;
    test_reset();
    test_8n1();
    test_parity();
    test_len_stop();
    test_midframe_reset();
    test_back_to_back();
    test_wide();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
